// File: rtl/cl_result_packer.sv
// cl_result_packer: packs IN_WIDTH results into OUT_WIDTH lines with padding of the final partial line and a done flag.
module cl_result_packer #(
  parameter int IN_WIDTH = 64,
  parameter int OUT_WIDTH = 512,
  parameter int COUNT_WIDTH = 32,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0,
  parameter int LANES = OUT_WIDTH / IN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [COUNT_WIDTH-1:0] total_results,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] lines_out,
  output logic                   busy,
  output logic                   done
);
  localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [COUNT_WIDTH-1:0] total_q, cnt;
  logic [IDX_W-1:0] idx;
  logic [LANES-1:0][IN_WIDTH-1:0] fill_q, line_nx, out_q;
  logic fill_full, out_full, out_free, acc, last, complete, start;
  assign start = go && (state == IDLE || state == DONE);
  assign out_free = !out_full || out_ready;
  assign last = cnt + COUNT_WIDTH'(1) == total_q;
  assign acc = in_valid && in_ready;
  assign complete = acc && (idx == IDX_W'(LANES - 1) || last);
  assign out_data = out_q;
  assign out_valid = out_full;
  // Lanes above the final result of the run are padded as the line completes.
  always_comb begin
    line_nx = fill_q;
    for (int k = 0; k < LANES; k++)
      line_nx[k] = IDX_W'(k) == idx ? in_data : (last && IDX_W'(k) > idx) ? PAD_VALUE : fill_q[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (go) state_nx = total_results == '0 ? DONE : FILL;
      FILL:       if (acc && last) state_nx = DRAIN;
      DRAIN:      if (!out_full && !fill_full) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == FILL && cnt != total_q && !(fill_full && !out_free);
    busy = state == FILL || state == DRAIN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      total_q <= '0;
      cnt <= '0;
      idx <= '0;
      lines_out <= '0;
      fill_q <= '0;
      out_q <= '0;
      fill_full <= 1'b0;
      out_full <= 1'b0;
    end else begin
      if (start) begin
        total_q <= total_results;
        cnt <= '0;
        idx <= '0;
      end else if (acc) begin
        cnt <= cnt + COUNT_WIDTH'(1);
        idx <= complete ? '0 : idx + IDX_W'(1);
        fill_q <= line_nx;
      end
      if (start) lines_out <= '0;
      else if (out_full && out_ready && !(&lines_out)) lines_out <= lines_out + COUNT_WIDTH'(1);
      // A held line always goes out before the line completing this cycle.
      if (fill_full && out_free) out_q <= fill_q;
      else if (complete && out_free) out_q <= line_nx;
      out_full <= out_free && (fill_full || complete) ? 1'b1 : out_full && !out_ready;
      fill_full <= fill_full ? (!out_free || complete) : (complete && !out_free);
    end
endmodule

// File: tb/tb_cl_result_packer.sv
// tb_cl_result_packer: directed and randomized runs checked against a line-level model.
module tb_cl_result_packer;
  localparam int W = 64, OW = 512, L = 8, CW = 32, W2 = 32, L2 = 16;
  localparam logic [W2-1:0] PAD2 = 32'hDEADBEEF;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic go = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, busy, done;
  logic [CW-1:0] total_results = '0, lines_out;
  logic [W-1:0] in_data = '0;
  logic [OW-1:0] out_data;
  logic go2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0, in_ready2, out_valid2, busy2, done2;
  logic [CW-1:0] total2 = '0, lines_out2;
  logic [W2-1:0] in_data2 = '0;
  logic [OW-1:0] out_data2;
  int checks = 0, errors = 0;

  cl_result_packer dut (
    .clk(clk), .rst_n(rst_n), .go(go), .total_results(total_results),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .lines_out(lines_out), .busy(busy), .done(done));

  cl_result_packer #(.IN_WIDTH(W2), .OUT_WIDTH(OW), .PAD_VALUE(PAD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .go(go2), .total_results(total2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .lines_out(lines_out2), .busy(busy2), .done(done2));

  task automatic chk(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_lines_out"}, lines_out, 0);
  endtask

  // Enters and leaves at posedge+1; base < 0 selects random data.
  task automatic run(int n, longint base, int vp, int rp, int hold, int mid_go, int rst_after);
    logic [W-1:0] d[$];
    logic [OW-1:0] el[$];
    logic [OW-1:0] prev = '0, line;
    int acc = 0, got = 0, cyc = 0, first = -1, lastc = -1;
    bit stall = 0, fin = 0;
    for (int i = 0; i < n; i++) d.push_back(base >= 0 ? W'(base + i) : {$urandom, $urandom});
    for (int j = 0; j < (n + L - 1) / L; j++) begin
      line = '0;
      for (int k = 0; k < L; k++) line[k*W +: W] = j * L + k < n ? d[j*L+k] : '0;
      el.push_back(line);
    end
    go = 1'b1;
    total_results = n;
    @(posedge clk); #1;
    go = 1'b0;
    total_results = $urandom;
    while (!fin && cyc < 3000) begin
      in_valid = acc < n && $urandom_range(99) < vp;
      in_data = acc < n ? d[acc] : '0;
      out_ready = cyc >= hold && $urandom_range(99) < rp;
      go = mid_go > 0 && cyc == mid_go;
      if (go) total_results = 3;
      @(negedge clk);
      if (cyc == 0) begin
        chk("go_clears_done", done, 0);
        chk("go_sets_busy", busy, 1);
      end
      if (in_valid && in_ready) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        acc++;
      end
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("line%0d", got), out_data, got < el.size() ? el[got] : 'x);
        got++;
      end
      stall = out_valid && !out_ready;
      prev = out_data;
      if (hold >= 20 && cyc == hold - 1) begin
        chk("bp_accepts", acc, 2 * L);
        chk("bp_in_ready", in_ready, 0);
      end
      if (rst_after > 0 && acc == rst_after) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_zero("async_rst");
        chk("rst_no_line", got, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (done) fin = 1;
      @(posedge clk); #1;
      go = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("run_finished", fin, 1);
    chk("accepted", acc, n);
    chk("lines_seen", got, el.size());
    chk("lines_out", lines_out, el.size());
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 0);
    chk("out_valid_end", out_valid, 0);
    if (vp == 100 && rp == 100 && hold == 0) chk("no_bubble", lastc - first + 1, n);
  endtask

  initial begin
    logic [W2-1:0] d2[$];
    logic [OW-1:0] el2[$];
    logic [OW-1:0] line;
    int acc, got;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 64'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    run(16, 1, 100, 100, 0, 0, 0);
    run(11, 'hA0, 100, 100, 0, 0, 0);
    run(24, 'h300, 100, 100, 20, 0, 0);
    go = 1'b1;
    total_results = 0;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_out_valid", out_valid, 0);
    chk("zero_lines_out", lines_out, 0);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;
    run(16, 'h40, 100, 100, 0, 3, 0);
    run(16, 'h100, 100, 100, 0, 0, 5);
    run(8, 'h200, 100, 100, 0, 0, 0);
    for (int r = 0; r < 6; r++) run($urandom_range(1, 40), -1, 70, 60, 0, 0, 0);
    run(L, -1, 100, 100, 0, 0, 0);
    run(1, -1, 100, 100, 0, 0, 0);
    for (int i = 0; i < 17; i++) d2.push_back($urandom);
    for (int j = 0; j < 2; j++) begin
      line = '0;
      for (int k = 0; k < L2; k++) line[k*W2 +: W2] = j * L2 + k < 17 ? d2[j*L2+k] : PAD2;
      el2.push_back(line);
    end
    go2 = 1'b1;
    total2 = 17;
    @(posedge clk); #1;
    go2 = 1'b0;
    acc = 0;
    got = 0;
    for (int c = 0; c < 200 && !done2; c++) begin
      in_valid2 = acc < 17;
      in_data2 = acc < 17 ? d2[acc] : '0;
      out_ready2 = 1'b1;
      @(negedge clk);
      if (in_valid2 && in_ready2) acc++;
      if (out_valid2 && out_ready2) begin
        chk($sformatf("sweep_line%0d", got), out_data2, got < el2.size() ? el2[got] : 'x);
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    chk("sweep_lines_seen", got, 2);
    chk("sweep_lines_out", lines_out2, 2);
    chk("sweep_done", done2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
